// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle controller.
// States, opcode map, ALU operation codes, datapath mux selects and branch helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JALR   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        A_PC    = 2'd0,
        A_RS1   = 2'd1,
        A_OLDPC = 2'd2
    } src_a_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_FOUR = 2'd1,
        B_IMM  = 2'd2
    } src_b_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2,
        WB_IMM    = 2'd3
    } wb_src_e;

    // Only beq (000) and bne (001) are implemented.
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3[2:1] == 2'b00);
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3 and instr[30] to an ALU operation for R-type and I-type ALU instructions.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_bit30,
    input  logic       i_is_rtype,
    output alu_op_e    o_alu_op
);

    logic w_alt;

    // For I-type, bit 30 belongs to the immediate except on srai.
    assign w_alt = i_bit30 & (i_is_rtype | (i_funct3 == 3'b101));

    // funct3 to operation, with the alternate encoding selecting SUB/SRA.
    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_funct3)
            3'b000:  o_alu_op = w_alt ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_op = ALU_SLL;
            3'b010:  o_alu_op = ALU_SLT;
            3'b011:  o_alu_op = ALU_SLTU;
            3'b100:  o_alu_op = ALU_XOR;
            3'b101:  o_alu_op = w_alt ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_op = ALU_OR;
            3'b111:  o_alu_op = ALU_AND;
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences the shared datapath over one memory port.
// Outputs decode from state, instr and the live mem_ready/zero inputs; all forced low during reset.
module mc_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_src,
    output logic        illegal
);

    state_e  r_state;
    state_e  w_next;
    logic    r_illegal;

    logic    w_mem_req;
    logic    w_mem_we;
    logic    w_iord;
    logic    w_ir_write;
    logic    w_pc_write;
    pc_src_e w_pc_src;
    src_a_e  w_src_a;
    src_b_e  w_src_b;
    alu_op_e w_alu_op;
    alu_op_e w_dec_alu_op;
    logic    w_reg_write;
    wb_src_e w_wb_src;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused_bits;

    assign w_opcode      = instr[6:0];
    assign w_funct3      = instr[14:12];
    assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .i_funct3   (w_funct3),
        .i_bit30    (instr[30]),
        .i_is_rtype (w_opcode == OP_RTYPE),
        .o_alu_op   (w_dec_alu_op)
    );

    // State and sticky trap flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    // Next-state and per-state datapath control decode.
    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_iord      = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = PC_ALU;
        w_src_a     = A_PC;
        w_src_b     = B_RS2;
        w_alu_op    = ALU_ADD;
        w_reg_write = 1'b0;
        w_wb_src    = WB_ALUOUT;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b0;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_ALU;
                    w_src_a    = A_PC;
                    w_src_b    = B_FOUR;
                    w_alu_op   = ALU_ADD;
                    w_next     = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU-out captures old PC + immediate for branch/jal targets.
                w_src_a  = A_OLDPC;
                w_src_b  = B_IMM;
                w_alu_op = ALU_ADD;
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADDR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                w_src_a  = A_RS1;
                w_src_b  = B_IMM;
                w_alu_op = ALU_ADD;
                if (w_opcode == OP_STORE) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else begin
                    w_next = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                w_wb_src    = WB_MDR;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_MEMWRITE;
                end
            end
            S_EXEC_R: begin
                w_src_a  = A_RS1;
                w_src_b  = B_RS2;
                w_alu_op = w_dec_alu_op;
                w_next   = S_ALUWB;
            end
            S_EXEC_I: begin
                w_src_a  = A_RS1;
                w_src_b  = B_IMM;
                w_alu_op = w_dec_alu_op;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_wb_src    = WB_ALUOUT;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a  = A_RS1;
                w_src_b  = B_RS2;
                w_alu_op = ALU_SUB;
                if (!branch_legal(w_funct3)) begin
                    w_next = S_TRAP;
                end else if (branch_taken(w_funct3, zero)) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_ALUOUT;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_JAL: begin
                // PC still holds pc+4 here, so it is the link value.
                w_pc_write  = 1'b1;
                w_pc_src    = PC_ALUOUT;
                w_reg_write = 1'b1;
                w_wb_src    = WB_PC;
                w_next      = S_FETCH;
            end
            S_JALR: begin
                w_src_a     = A_RS1;
                w_src_b     = B_IMM;
                w_alu_op    = ALU_ADD;
                w_pc_write  = 1'b1;
                w_pc_src    = PC_JALR;
                w_reg_write = 1'b1;
                w_wb_src    = WB_PC;
                w_next      = S_FETCH;
            end
            S_LUI: begin
                w_reg_write = 1'b1;
                w_wb_src    = WB_IMM;
                w_next      = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Reset forces every control output low, even though the state is FETCH.
    assign {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
            alu_op, reg_write, wb_src} =
        rst_n ? {w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_src, w_src_a,
                 w_src_b, w_alu_op, w_reg_write, w_wb_src}
              : 18'd0;

    assign illegal = r_illegal;

endmodule
